// File: rtl/prbs_rx_ctrl_if.sv
// Handshake/data bundle between the PRBS receive sequencer and its neighbours:
// pattern detector flag, received/generator bytes, generator controls and status.
interface prbs_rx_ctrl_if #(
  parameter int BusWidth = 8,
  parameter int CntWidth = 16
);
  logic                Start;
  logic                Abort;
  logic                DetFlag;
  logic [BusWidth-1:0] InData;
  logic [BusWidth-1:0] PrbsByte;
  logic                PrbsLoad;
  logic                PrbsEn;
  logic                Busy;
  logic                Done;
  logic                Pass;
  logic                TimeoutErr;
  logic [CntWidth-1:0] ErrCnt;
  logic [CntWidth-1:0] BitErrCnt;

  modport master (
    output Start, Abort, DetFlag, InData, PrbsByte,
    input  PrbsLoad, PrbsEn, Busy, Done, Pass, TimeoutErr, ErrCnt, BitErrCnt
  );

  modport slave (
    input  Start, Abort, DetFlag, InData, PrbsByte,
    output PrbsLoad, PrbsEn, Busy, Done, Pass, TimeoutErr, ErrCnt, BitErrCnt
  );
endinterface

// File: rtl/prbs_rx_ctrl.sv
// PRBS-15 receive sequencer: waits for the detector flag, seeds the local generator,
// compares a fixed number of bytes and reports saturating byte/bit error counts.
module prbs_rx_ctrl #(
  parameter int          BusWidth  = 8,
  parameter int          CntWidth  = 16,
  parameter int unsigned NumBytes  = 1024,
  parameter int unsigned Timeout   = 4096,
  parameter int unsigned ErrThresh = 0
) (
  input logic           CLK,
  input logic           RST,
  prbs_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DET = 3'd1,
    SEED     = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int PcW  = $clog2(BusWidth + 1);
  localparam int SumW = ((CntWidth > PcW) ? CntWidth : PcW) + 1;
  localparam logic [CntWidth-1:0] CntMax   = '1;
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0] LastWait = CntWidth'(Timeout - 1);
  localparam logic [CntWidth-1:0] LastByte = CntWidth'(NumBytes - 1);

  function automatic logic [SumW-1:0] popcount(input logic [BusWidth-1:0] v);
    logic [SumW-1:0] c;
    c = '0;
    for (int i = 0; i < BusWidth; i++) c = c + SumW'(v[i]);
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CntWidth-1:0] byte_cnt_q, byte_cnt_d;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [CntWidth-1:0] bit_err_cnt_q, bit_err_cnt_d;
  logic                pass_q, pass_d;
  logic                timeout_err_q, timeout_err_d;
  logic                prbs_load_q, prbs_load_d;
  logic                prbs_en_q, prbs_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BusWidth-1:0] diff;
  logic [SumW-1:0]     bit_sum;
  logic                clear_run;

  always_comb begin
    state_d       = state_q;
    cyc_cnt_d     = cyc_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    err_cnt_d     = err_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;
    pass_d        = pass_q;
    timeout_err_d = timeout_err_q;
    clear_run     = 1'b0;
    diff          = bus.InData ^ bus.PrbsByte;
    bit_sum       = SumW'(bit_err_cnt_q) + popcount(diff);

    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d   = WAIT_DET;
          clear_run = 1'b1;
        end
      end
      WAIT_DET: begin
        cyc_cnt_d = cyc_cnt_q + CntOne;
        // A flag arriving on the last allowed cycle still counts as detected.
        if (bus.DetFlag) begin
          state_d = SEED;
        end else if (cyc_cnt_q == LastWait) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
        end
      end
      SEED: state_d = CHECK;
      CHECK: begin
        byte_cnt_d = byte_cnt_q + CntOne;
        if (|diff) begin
          err_cnt_d     = (err_cnt_q == CntMax) ? CntMax : err_cnt_q + CntOne;
          bit_err_cnt_d = (bit_sum > SumW'(CntMax)) ? CntMax : bit_sum[CntWidth-1:0];
        end
        if (byte_cnt_q == LastByte) begin
          state_d = DONE;
          pass_d  = (32'(err_cnt_d) <= ErrThresh);
        end
      end
      default: begin
        state_d   = IDLE;
        clear_run = 1'b1;
      end
    endcase

    if (bus.Abort) begin
      state_d   = IDLE;
      clear_run = 1'b1;
    end

    if (clear_run) begin
      cyc_cnt_d     = '0;
      byte_cnt_d    = '0;
      err_cnt_d     = '0;
      bit_err_cnt_d = '0;
      pass_d        = 1'b0;
      timeout_err_d = 1'b0;
    end

    // Strobes decode the next state so they are registered yet track state_q exactly.
    prbs_load_d = (state_d == SEED);
    prbs_en_d   = (state_d == CHECK);
    busy_d      = (state_d == WAIT_DET) || (state_d == SEED) || (state_d == CHECK);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      cyc_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      err_cnt_q     <= '0;
      bit_err_cnt_q <= '0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      prbs_load_q   <= 1'b0;
      prbs_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_cnt_q     <= cyc_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      err_cnt_q     <= err_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      prbs_load_q   <= prbs_load_d;
      prbs_en_q     <= prbs_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.PrbsLoad   = prbs_load_q;
  assign bus.PrbsEn     = prbs_en_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Pass       = pass_q;
  assign bus.TimeoutErr = timeout_err_q;
  assign bus.ErrCnt     = err_cnt_q;
  assign bus.BitErrCnt  = bit_err_cnt_q;

endmodule

// File: tb/tb_prbs_rx_ctrl.sv
// Directed bench for prbs_rx_ctrl: per-cycle vector table plus an async-reset sequence.
// DUT a: 16-bit counters, 16 bytes, timeout 10; DUT b: 4-bit counters, 15 bytes.
module tb_prbs_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_rx_ctrl_if #(.BusWidth(8), .CntWidth(16)) ifa ();
  prbs_rx_ctrl_if #(.BusWidth(8), .CntWidth(4))  ifb ();

  prbs_rx_ctrl #(.BusWidth(8), .CntWidth(16), .NumBytes(16), .Timeout(10), .ErrThresh(0))
    dut_a (.CLK(clk), .RST(rst_n), .bus(ifa));
  prbs_rx_ctrl #(.BusWidth(8), .CntWidth(4), .NumBytes(15), .Timeout(10), .ErrThresh(0))
    dut_b (.CLK(clk), .RST(rst_n), .bus(ifb));

  // Simple PRBS-15 generator models (x^15 + x^14 + 1), 8 bits per step.
  logic [14:0] lfsr_a, lfsr_b;
  logic [7:0]  mask_a, mask_b;

  function automatic logic [14:0] step8(input logic [14:0] s);
    logic [14:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[13:0], r[14] ^ r[13]};
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_a <= 15'h0001;
    else if (ifa.PrbsLoad) lfsr_a <= 15'h7FFF;
    else if (ifa.PrbsEn) lfsr_a <= step8(lfsr_a);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_b <= 15'h0001;
    else if (ifb.PrbsLoad) lfsr_b <= 15'h7FFF;
    else if (ifb.PrbsEn) lfsr_b <= step8(lfsr_b);
  end

  assign ifa.PrbsByte = lfsr_a[7:0];
  assign ifa.InData   = lfsr_a[7:0] ^ mask_a;
  assign ifb.PrbsByte = lfsr_b[7:0];
  assign ifb.InData   = lfsr_b[7:0] ^ mask_b;

  // Expected output packing: {load, en, busy, done, pass, tmo, err[15:0], bit[15:0]}
  typedef struct {
    string       name;
    int          sel;
    bit          start;
    bit          abort;
    bit          det;
    logic [7:0]  mask;
    logic [37:0] exp;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] byte_mask [16];

  function automatic logic [37:0] observe(input int sel);
    if (sel == 0)
      return {ifa.PrbsLoad, ifa.PrbsEn, ifa.Busy, ifa.Done, ifa.Pass, ifa.TimeoutErr,
              ifa.ErrCnt, ifa.BitErrCnt};
    return {ifb.PrbsLoad, ifb.PrbsEn, ifb.Busy, ifb.Done, ifb.Pass, ifb.TimeoutErr,
            12'h000, ifb.ErrCnt, 12'h000, ifb.BitErrCnt};
  endfunction

  task automatic add(input string nm, input int sel, input bit st, input bit ab, input bit det,
                     input logic [7:0] mk, input bit ld, input bit en, input bit bz,
                     input bit dn, input bit ps, input bit to,
                     input logic [15:0] er, input logic [15:0] bt);
    vec_t v;
    v.name  = nm;
    v.sel   = sel;
    v.start = st;
    v.abort = ab;
    v.det   = det;
    v.mask  = mk;
    v.exp   = {ld, en, bz, dn, ps, to, er, bt};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    ifa.Start = 1'b0; ifa.Abort = 1'b0; ifa.DetFlag = 1'b0; mask_a = 8'h00;
    ifb.Start = 1'b0; ifb.Abort = 1'b0; ifb.DetFlag = 1'b0; mask_b = 8'h00;
  endtask

  task automatic check(input string nm, input logic [37:0] got, input logic [37:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end else begin
      $display("ok   %s out=%h", nm, got);
    end
  endtask

  task automatic apply_all();
    foreach (vecs[i]) begin
      drive_idle();
      if (vecs[i].sel == 0) begin
        ifa.Start = vecs[i].start; ifa.Abort = vecs[i].abort;
        ifa.DetFlag = vecs[i].det; mask_a = vecs[i].mask;
      end else begin
        ifb.Start = vecs[i].start; ifb.Abort = vecs[i].abort;
        ifb.DetFlag = vecs[i].det; mask_b = vecs[i].mask;
      end
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", vecs[i].name, i), observe(vecs[i].sel), vecs[i].exp);
    end
    drive_idle();
    vecs.delete();
  endtask

  // Full run: Start, wait_n quiet detector cycles, flag, seed, nb checked bytes, one hold cycle.
  // Intermediate counts follow byte_mask; the final values are hand-supplied.
  task automatic run_seq(input string nm, input int sel, input int nb, input int wait_n,
                         input int start_byte, input logic [15:0] fin_err,
                         input logic [15:0] fin_bit, input bit fin_pass);
    int maxc;
    int e;
    int b;
    maxc = (sel == 0) ? 65535 : 15;
    e = 0;
    b = 0;
    add(nm, sel, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    for (int i = 0; i < wait_n; i++)
      add(nm, sel, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add(nm, sel, 0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add(nm, sel, 0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 16'd0, 16'd0);
    for (int k = 0; k < nb; k++) begin
      if (byte_mask[k] != 8'h00) begin
        e = (e + 1 > maxc) ? maxc : e + 1;
        b = (b + $countones(byte_mask[k]) > maxc) ? maxc : b + $countones(byte_mask[k]);
      end
      if (k < nb - 1)
        add(nm, sel, (k == start_byte), 0, 1, byte_mask[k], 0, 1, 1, 0, 0, 0, 16'(e), 16'(b));
      else
        add(nm, sel, 0, 0, 1, byte_mask[k], 0, 0, 0, 1, fin_pass, 0, fin_err, fin_bit);
    end
    add({nm, "_hold"}, sel, 0, 0, 0, 8'h00, 0, 0, 0, 1, fin_pass, 0, fin_err, fin_bit);
  endtask

  initial begin
    drive_idle();
    foreach (byte_mask[k]) byte_mask[k] = 8'h00;

    #2;
    check("reset_a", observe(0), 38'h0);
    check("reset_b", observe(1), 38'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    add("idle_a", 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    add("idle_b", 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    apply_all();

    // Clean run, flag 3 cycles after Start.
    run_seq("clean", 0, 16, 2, -1, 16'd0, 16'd0, 1'b1);
    apply_all();

    // Byte 2 fully inverted, last byte one bit off: 2 bytes, 9 bits.
    byte_mask[2]  = 8'hFF;
    byte_mask[15] = 8'h01;
    run_seq("errors", 0, 16, 2, -1, 16'd2, 16'd9, 1'b0);
    apply_all();
    foreach (byte_mask[k]) byte_mask[k] = 8'h00;

    // Timeout: 10 cycles in WAIT_DET without the flag.
    add("tmo", 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    for (int i = 0; i < 9; i++)
      add("tmo", 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add("tmo_end", 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 16'd0, 16'd0);
    add("tmo_hold", 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 16'd0, 16'd0);
    apply_all();

    // Flag on the 10th WAIT_DET cycle wins over timeout; Start mid-CHECK ignored.
    run_seq("det_at_10", 0, 16, 9, 5, 16'd0, 16'd0, 1'b1);
    apply_all();

    // Abort together with Start mid-CHECK returns to IDLE with everything cleared.
    add("abort", 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add("abort", 0, 0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add("abort", 0, 0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 16'd0, 16'd0);
    add("abort", 0, 0, 0, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 16'd1, 16'd8);
    add("abort", 0, 0, 0, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 16'd2, 16'd16);
    add("abort", 0, 0, 0, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 16'd3, 16'd24);
    add("abort_start", 0, 1, 1, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    add("abort_idle", 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0);
    apply_all();

    // Saturation on 4-bit counters: 15 fully inverted bytes.
    foreach (byte_mask[k]) byte_mask[k] = 8'hFF;
    run_seq("sat", 1, 15, 0, -1, 16'd15, 16'd15, 1'b0);
    apply_all();
    foreach (byte_mask[k]) byte_mask[k] = 8'h00;

    // Asynchronous reset mid-CHECK, between clock edges.
    add("pre_rst", 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add("pre_rst", 0, 0, 0, 1, 8'h00, 1, 0, 1, 0, 0, 0, 16'd0, 16'd0);
    add("pre_rst", 0, 0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++)
      add("pre_rst", 0, 0, 0, 1, (i == 1) ? 8'h0F : 8'h00, 0, 1, 1, 0, 0, 0,
          (i >= 1) ? 16'd1 : 16'd0, (i >= 1) ? 16'd4 : 16'd0);
    apply_all();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", observe(0), 38'h0);
    check("async_rst_b", observe(1), 38'h0);
    @(posedge clk);
    #1;
    check("rst_held_a", observe(0), 38'h0);
    rst_n = 1'b1;

    run_seq("post_rst", 0, 16, 2, -1, 16'd0, 16'd0, 1'b1);
    apply_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prbs_rx_ctrl.md
Name: prbs_rx_ctrl

Overview:
Receive-side sequencer for the PRBS-15 link. After a Start command it waits for the pattern detector's sticky Flag, which marks a valid preamble received nPatternDetector times. It then seeds and steps the local PRBS-15 generator, compares each received byte against the generator byte for a programmed length, and reports byte/bit error counts with a pass/fail verdict. It sits between the pattern detector, the PRBS generator and the status/host interface.

Parameters:
BusWidth, 8, width of received and generator data bytes
CntWidth, 16, width of byte, error and timeout counters
NumBytes, 16'd1024, number of bytes checked per run; legal range 1..2^CntWidth-1
Timeout, 16'd4096, max cycles spent waiting for DetFlag; legal range 1..2^CntWidth-1
ErrThresh, 16'd0, max byte errors still reported as Pass

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous active-low reset
Start  in  1  single-cycle run request; accepted only in IDLE or DONE
Abort  in  1  single-cycle cancel; returns to IDLE from any state
DetFlag  in  1  pattern detector Flag, sticky once set
InData  in  BusWidth  received byte, one per cycle
PrbsByte  in  BusWidth  current PRBS generator output byte
PrbsLoad  out  1  generator seed-load strobe
PrbsEn  out  1  generator advance enable
Busy  out  1  high in WAIT_DET, SEED and CHECK
Done  out  1  high in DONE
Pass  out  1  verdict, valid while Done=1
TimeoutErr  out  1  run ended by WAIT_DET timeout, valid while Done=1
ErrCnt  out  CntWidth  mismatching byte count, saturating
BitErrCnt  out  CntWidth  mismatching bit count (popcount of InData^PrbsByte), saturating

Behaviour:
- Reset: state IDLE; every output 0; all counters 0.
- States: IDLE, WAIT_DET, SEED, CHECK, DONE. PrbsLoad, PrbsEn, Busy and Done are Moore decodes of the state. Counters, Pass and TimeoutErr are registers.
- IDLE: Start -> WAIT_DET; the cycle count, byte count, ErrCnt, BitErrCnt, Pass and TimeoutErr are cleared on that edge.
- WAIT_DET: the cycle counter increments every cycle.
  - DetFlag=1 -> SEED. DetFlag takes priority over timeout in the same cycle.
  - Else, when the counter reaches Timeout-1 -> DONE with TimeoutErr=1 and Pass=0.
- SEED: exactly 1 cycle; PrbsLoad=1, PrbsEn=0; always -> CHECK.
- CHECK: PrbsEn=1 every cycle.
  - Each cycle InData is compared to PrbsByte. The first compared byte is the cycle right after SEED.
  - On a mismatch, ErrCnt increments by 1 and BitErrCnt increments by the popcount of the XOR.
  - Both counters saturate at all-ones. BitErrCnt saturates and does not wrap when the add overflows.
  - The byte counter increments every cycle. In the cycle the byte counter equals NumBytes-1, that byte is still compared and counted, then -> DONE.
  - On the CHECK->DONE edge, Pass = (final ErrCnt <= ErrThresh), using the count that includes the last byte.
- DONE: Done=1; Pass, TimeoutErr, ErrCnt and BitErrCnt hold. Start -> WAIT_DET with the counters cleared, as in IDLE.
- Start is ignored in WAIT_DET, SEED and CHECK.
- Abort, in any state, -> IDLE next edge and clears all counters and status. Abort wins over Start and over every other transition in the same cycle.
- DetFlag is not re-checked in CHECK. Loss of alignment shows up only as errors.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0, with no wait for a clock edge.
- Unused state encodings -> IDLE.

Test Plan:
- Clean run, NumBytes=16: Start, DetFlag rises 3 cycles later, InData==PrbsByte throughout -> SEED 1 cycle, PrbsEn high 16 cycles, Done=1, Pass=1, ErrCnt=0, BitErrCnt=0.
- Errors, NumBytes=16, ErrThresh=0: invert InData (XOR 8'hFF) on byte 2 and XOR 8'h01 on the last byte -> ErrCnt=2, BitErrCnt=9, Pass=0.
- Timeout, Timeout=10: Start with DetFlag held 0 -> Done after exactly 10 cycles in WAIT_DET, TimeoutErr=1, Pass=0, PrbsLoad never asserted. Repeat with DetFlag rising on cycle 10 -> goes to SEED, no timeout.
- Saturation, CntWidth=4, NumBytes=15: all bytes fully inverted -> ErrCnt=15, BitErrCnt=15, no wrap.
- Abort/Start priority: assert Abort and Start together mid-CHECK -> IDLE, counters 0. Start during CHECK alone -> ignored, run completes normally.
- Asynchronous reset mid-CHECK, then a fresh Start -> all outputs 0 immediately, new run behaves like the clean-run case.
